apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/defines_pkg.sv | 27 ++
 rtl/apb_timeout_cnt.sv | 41 ++++
 rtl/apb_master.sv | 172 +++++++++++++++++
 tb/tb_apb_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/defines_pkg.sv
`default_nettype none
// ============================================================================
// Module   : defines_pkg
// Purpose  : Shared widths, command-word bit positions and the APB master
//            state type used by apb_master and apb_timeout_cnt.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package defines_pkg;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int CMD_W        = 66;
   localparam int CMD_RW_BIT   = 64;
   localparam int CMD_ADDR_MSB = 63;
   localparam int CMD_ADDR_LSB = 32;
   localparam int CMD_DATA_MSB = 31;
   localparam int CMD_DATA_LSB = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

endpackage : defines_pkg
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : apb_timeout_cnt
// Purpose  : Counts ACCESS-phase cycles in which the completer is not ready
//            and flags the cycle on which the TIMEOUT_CYCLES-th such cycle
//            occurs.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            clear          - restart the count (outside ACCESS)
//            count_en       - ACCESS cycle with pready_i low
//            expired        - this not-ready cycle is the TIMEOUT_CYCLES-th
// Revision : 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Holds the number of not-ready cycles already seen in this ACCESS phase.
   logic [CNT_W-1:0] r_cnt;

   assign expired = count_en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (count_en && !expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : apb_timeout_cnt
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Pops commands from a first-word-fall-through FIFO and executes
//            each one as a single APB transfer (IDLE -> SETUP -> ACCESS).
//            Read completions return as a one-cycle rd_valid_o pulse.
// Config   : APB_TIMEOUT_EN - when defined, an ACCESS phase that sees
//            TIMEOUT_CYCLES not-ready cycles is aborted with err_o/timeout_o
//            (and rd_valid_o with zero data for reads). Undefined: ACCESS
//            waits forever and timeout_o is tied low.
// Ports    : clk, rst (async, active-high)
//            fifo_empty_i, fifo_data_i, fifo_rd_en_o   - command FIFO
//            psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
//            prdata_i, pready_i, pslverr_i             - APB requester
//            rd_valid_o, rd_data_o                     - read completion
//            err_o, timeout_o, busy_o                  - status
// Revision : 1.0 - initial release
// ============================================================================
module apb_master
   import defines_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty_i,
   input  logic [CMD_W-1:0]  fifo_data_i,
   output logic              fifo_rd_en_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i,
   input  logic              pslverr_i,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              err_o,
   output logic              timeout_o,
   output logic              busy_o
);

   apb_state_t        r_state;
   apb_state_t        w_next;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rd_valid;
   logic              r_err;
   logic [DATA_W-1:0] r_rd_data;
   logic              w_pop;
   logic              w_done;
   logic              w_tmo;
   logic              w_unused_rsvd;

   // Bit 65 of the command word is reserved.
   assign w_unused_rsvd = fifo_data_i[CMD_W-1];

   // Gated by rst so the FIFO is never popped while the block is held in reset.
   assign w_pop  = (r_state == IDLE) && !fifo_empty_i && !rst;
   assign w_done = (r_state == ACCESS) && pready_i;

`ifdef APB_TIMEOUT_EN
   logic r_timeout;

   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (r_state != ACCESS),
      .count_en ((r_state == ACCESS) && !pready_i),
      .expired  (w_tmo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_tmo;
      end
   end

   assign timeout_o = r_timeout;
`else
   localparam int C_UNUSED_TMO = TIMEOUT_CYCLES;

   assign w_tmo     = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      psel_o    = 1'b0;
      penable_o = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pop) begin
               w_next = SETUP;
            end
         end
         SETUP: begin
            psel_o = 1'b1;
            w_next = ACCESS;
         end
         ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            if (w_done || w_tmo) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Command latch and completion pulses. rd_data_o only changes when a read
   // finishes, so it holds across writes and idle periods.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
         if (w_pop) begin
            r_rw    <= fifo_data_i[CMD_RW_BIT];
            r_addr  <= fifo_data_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
            r_wdata <= fifo_data_i[CMD_DATA_MSB:CMD_DATA_LSB];
         end
         if (w_done) begin
            r_rd_valid <= !r_rw;
            r_err      <= pslverr_i;
            if (!r_rw) begin
               r_rd_data <= prdata_i;
            end
         end else if (w_tmo) begin
            r_rd_valid <= !r_rw;
            r_err      <= 1'b1;
            if (!r_rw) begin
               r_rd_data <= '0;
            end
         end
      end
   end

   assign fifo_rd_en_o = w_pop;
   assign pwrite_o     = r_rw;
   assign paddr_o      = r_addr;
   assign pwdata_o     = r_wdata;
   assign rd_valid_o   = r_rd_valid;
   assign rd_data_o    = r_rd_data;
   assign err_o        = r_err;
   assign busy_o       = (r_state != IDLE);

endmodule : apb_master
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Self-checking bench for apb_master. Commands are issued one at a
//            time from a FIFO model; each transfer is checked phase by phase
//            against the expected APB behaviour and completion result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic [65:0] fifo_data;
   logic        fifo_rd_en;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic        pready, pslverr;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        err, timeout, busy;

   int          n_checks = 0;
   int          n_errors = 0;
   int          pops     = 0;
   int          exp_pops = 0;
   logic [31:0] model_rd_data;

   apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty_i (fifo_empty),
      .fifo_data_i  (fifo_data),
      .fifo_rd_en_o (fifo_rd_en),
      .psel_o       (psel),
      .penable_o    (penable),
      .pwrite_o     (pwrite),
      .paddr_o      (paddr),
      .pwdata_o     (pwdata),
      .prdata_i     (prdata),
      .pready_i     (pready),
      .pslverr_i    (pslverr),
      .rd_valid_o   (rd_valid),
      .rd_data_o    (rd_data),
      .err_o        (err),
      .timeout_o    (timeout),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fifo_rd_en) pops <= pops + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      check_eq("idle_rd_valid", rd_valid, 0);
      check_eq("idle_err", err, 0);
      check_eq("idle_timeout", timeout, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_psel", psel, 0);
      check_eq("idle_pop", fifo_rd_en, 0);
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the
   // IDLE cycle following completion (where the response pulse is visible).
   task automatic do_txn(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                         input int wait_n, input logic slverr, input logic [31:0] rdata);
      logic tmo;
      int   n_acc;
`ifdef APB_TIMEOUT_EN
      tmo = (wait_n >= TMO);
`else
      tmo = 1'b0;
`endif
      n_acc = tmo ? TMO : wait_n + 1;

      fifo_data  = {1'($urandom), rw, addr, data};
      fifo_empty = 1'b0;
      exp_pops++;
      #1;
      check_eq("pop_strobe", fifo_rd_en, 1);
      check_eq("pop_psel", psel, 0);
      check_eq("pop_busy", busy, 0);

      @(negedge clk);
      fifo_empty = 1'b1;
      fifo_data  = {$urandom, $urandom, 2'($urandom)};
      check_eq("setup_psel", psel, 1);
      check_eq("setup_penable", penable, 0);
      check_eq("setup_pwrite", pwrite, rw);
      check_eq("setup_paddr", paddr, addr);
      check_eq("setup_pwdata", pwdata, data);
      check_eq("setup_busy", busy, 1);
      check_eq("setup_pop", fifo_rd_en, 0);
      check_eq("setup_rd_valid", rd_valid, 0);
      check_eq("setup_err", err, 0);

      for (int k = 0; k < n_acc; k++) begin
         @(negedge clk);
         check_eq("acc_psel", psel, 1);
         check_eq("acc_penable", penable, 1);
         check_eq("acc_pwrite", pwrite, rw);
         check_eq("acc_paddr", paddr, addr);
         check_eq("acc_pwdata", pwdata, data);
         check_eq("acc_busy", busy, 1);
         check_eq("acc_pop", fifo_rd_en, 0);
         check_eq("acc_err", err, 0);
         check_eq("acc_timeout", timeout, 0);
         pready  = (!tmo && k == wait_n);
         pslverr = pready ? slverr : 1'($urandom);
         prdata  = pready ? rdata : $urandom;
      end

      @(negedge clk);
      pready  = 1'b0;
      pslverr = 1'b0;
      if (!rw) model_rd_data = tmo ? 32'h0 : rdata;
      check_eq("done_psel", psel, 0);
      check_eq("done_penable", penable, 0);
      check_eq("done_busy", busy, 0);
      check_eq("done_pop_empty", fifo_rd_en, 0);
      check_eq("done_rd_valid", rd_valid, !rw);
      check_eq("done_err", err, slverr | tmo);
      check_eq("done_timeout", timeout, tmo);
      check_eq("done_rd_data", rd_data, model_rd_data);
   endtask

   initial begin
      rst           = 1'b1;
      fifo_empty    = 1'b1;
      fifo_data     = '0;
      prdata        = '0;
      pready        = 1'b0;
      pslverr       = 1'b0;
      model_rd_data = '0;

      repeat (3) @(negedge clk);
      fifo_empty = 1'b0;
      #1;
      check_eq("rst_pop", fifo_rd_en, 0);
      check_eq("rst_psel", psel, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_paddr", paddr, 0);
      fifo_empty = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_cycle();

      // Single write, ready immediately.
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0);
      idle_cycle();
      // Read with four wait states.
      do_txn(1'b0, 32'h20, 32'h0, 4, 1'b0, 32'hCAFEF00D);
      idle_cycle();
      // Read with error; then read whose error appears only while not ready.
      do_txn(1'b0, 32'h30, 32'h1, 0, 1'b1, 32'h12345678);
      do_txn(1'b0, 32'h34, 32'h2, 3, 1'b0, 32'h87654321);
      // Back-to-back W, R, W; the write keeps rd_data unchanged.
      do_txn(1'b1, 32'h40, 32'hA5A5A5A5, 1, 1'b0, 32'h0);
      do_txn(1'b0, 32'h44, 32'h0, 0, 1'b0, 32'h0BADF00D);
      do_txn(1'b1, 32'h48, 32'h5A5A5A5A, 2, 1'b1, 32'h0);
      idle_cycle();
      // Ready on the last cycle before the limit completes normally.
      do_txn(1'b0, 32'h50, 32'h0, TMO - 1, 1'b0, 32'h11112222);
      // Stuck completer: times out when enabled, otherwise just waits.
      do_txn(1'b0, 32'h54, 32'h0, TMO + 4, 1'b0, 32'h33334444);
      idle_cycle();

      for (int i = 0; i < 30; i++) begin
         do_txn(1'($urandom), $urandom, $urandom, $urandom_range(0, 6),
                1'($urandom), $urandom);
      end
      idle_cycle();

      // Reset in the middle of ACCESS.
      fifo_data  = {1'b0, 1'b0, 32'h60, 32'h0};
      fifo_empty = 1'b0;
      exp_pops++;
      @(negedge clk);
      fifo_empty = 1'b1;
      @(negedge clk);
      #2;
      fifo_data  = {1'b0, 1'b0, 32'h64, 32'h0};
      fifo_empty = 1'b0;
      rst        = 1'b1;
      #1;
      model_rd_data = '0;
      check_eq("arst_psel", psel, 0);
      check_eq("arst_penable", penable, 0);
      check_eq("arst_pwrite", pwrite, 0);
      check_eq("arst_paddr", paddr, 0);
      check_eq("arst_pwdata", pwdata, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_pop", fifo_rd_en, 0);
      check_eq("arst_rd_data", rd_data, 0);
      @(negedge clk);
      check_eq("arst_rd_valid", rd_valid, 0);
      check_eq("arst_err", err, 0);
      check_eq("arst_timeout", timeout, 0);
      rst = 1'b0;
      do_txn(1'b0, 32'h64, 32'h0, 2, 1'b0, 32'hFEEDFACE);
      idle_cycle();

      check_eq("pop_count", pops, exp_pops);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_apb_master
`default_nettype wire
